// File: rtl/std_cache_pkg.sv
// Shared L1 data-cache types: the store-buffer entry layout and the drain FSM state encoding.
package std_cache_pkg;

   localparam int unsigned SB_PLEN = 56;
   localparam int unsigned SB_XLEN = 64;

   typedef struct packed {
      logic [SB_PLEN-1:0]   addr;
      logic [SB_XLEN-1:0]   data;
      logic [SB_XLEN/8-1:0] be;
      logic                 valid;
   } sb_entry_t;

   typedef enum logic [1:0] {
      SB_IDLE = 2'd0,
      SB_REQ  = 2'd1,
      SB_TAG  = 2'd2
   } sb_state_e;

endpackage

// File: rtl/sb_alias_cmp.sv
// Per-entry word-index comparator reduced to a single hit: any valid entry whose key equals the probe.
module sb_alias_cmp #(
   parameter int unsigned N = 4,
   parameter int unsigned W = 9
) (
   input  logic [N-1:0]   i_valid,
   input  logic [N*W-1:0] i_keys,
   input  logic [W-1:0]   i_probe,
   output logic           o_hit
);

   always_comb begin
      o_hit = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (i_valid[i] && (i_keys[i*W +: W] == i_probe)) o_hit = 1'b1;
      end
   end

endmodule

// File: rtl/dcache_store_drain_buffer.sv
// Store drain buffer: in-order FIFO of committed stores drained through the two-phase cache request port.
// Optional store coalescing into the tail entry is enabled by defining STORE_BUF_COALESCE_EN.
module dcache_store_drain_buffer
   import std_cache_pkg::*;
#(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned PLEN    = SB_PLEN,
   parameter int unsigned INDEX_W = 12,
   parameter int unsigned XLEN    = SB_XLEN
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    st_valid_i,
   output logic                    st_ready_o,
   input  logic [PLEN-1:0]         st_addr_i,
   input  logic [XLEN-1:0]         st_data_i,
   input  logic [XLEN/8-1:0]       st_be_i,
   input  logic [PLEN-1:0]         ld_addr_i,
   output logic                    ld_alias_o,
   output logic                    dc_data_req_o,
   input  logic                    dc_data_gnt_i,
   output logic [INDEX_W-1:0]      dc_addr_index_o,
   output logic                    dc_data_we_o,
   output logic [XLEN/8-1:0]       dc_data_be_o,
   output logic [XLEN-1:0]         dc_data_wdata_o,
   output logic                    dc_tag_valid_o,
   output logic [PLEN-INDEX_W-1:0] dc_addr_tag_o,
   input  logic                    flush_i,
   output logic                    flush_ack_o,
   output logic                    empty_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned BE_W  = XLEN / 8;
   localparam int unsigned CMP_W = INDEX_W - 3;

   sb_entry_t          r_mem [DEPTH];
   logic [PTR_W-1:0]   r_head;
   logic [PTR_W-1:0]   r_tail;
   logic [CNT_W-1:0]   r_count;
   sb_state_e          r_state;
   logic               r_ack_sent;

   sb_state_e          w_state_nxt;
   logic [CNT_W-1:0]   w_count_nxt;
   sb_entry_t          w_head;
   logic               w_full;
   logic               w_merge_hit;
   logic               w_push;
   logic               w_alloc;
   logic               w_pop;
   logic [DEPTH-1:0]   w_vld_vec;
   logic [DEPTH*CMP_W-1:0] w_key_vec;
   logic               w_unused_ld;

   assign w_head = r_mem[r_head];
   assign w_full = (r_count == CNT_W'(DEPTH));

`ifdef STORE_BUF_COALESCE_EN
   logic [PTR_W-1:0] w_tail_last;
   assign w_tail_last = r_tail - PTR_W'(1);
   // The head entry is frozen once its request is on the bus, so never merge into it then.
   assign w_merge_hit = r_mem[w_tail_last].valid
                        && (st_addr_i[PLEN-1:3] == r_mem[w_tail_last].addr[PLEN-1:3])
                        && !flush_i
                        && !((w_tail_last == r_head) && (r_state != SB_IDLE));
`else
   assign w_merge_hit = 1'b0;
`endif

   assign st_ready_o  = (!w_full || w_merge_hit) && !flush_i;
   assign w_push      = st_valid_i && st_ready_o;
   assign w_alloc     = w_push && !w_merge_hit;
   assign w_pop       = (r_state == SB_TAG);
   assign empty_o     = (r_count == '0);
   assign flush_ack_o = flush_i && !r_ack_sent && (r_state == SB_IDLE) && (r_count == '0);

   always_comb begin
      w_count_nxt = r_count;
      if (w_alloc && !w_pop)      w_count_nxt = r_count + CNT_W'(1);
      else if (!w_alloc && w_pop) w_count_nxt = r_count - CNT_W'(1);
   end

   always_comb begin
      w_state_nxt     = r_state;
      dc_data_req_o   = 1'b0;
      dc_data_we_o    = 1'b0;
      dc_addr_index_o = '0;
      dc_data_be_o    = '0;
      dc_data_wdata_o = '0;
      dc_tag_valid_o  = 1'b0;
      dc_addr_tag_o   = '0;
      unique case (r_state)
         SB_IDLE: if (r_count != '0) w_state_nxt = SB_REQ;
         SB_REQ: begin
            dc_data_req_o   = 1'b1;
            dc_data_we_o    = 1'b1;
            dc_addr_index_o = w_head.addr[INDEX_W-1:0];
            dc_data_be_o    = w_head.be;
            dc_data_wdata_o = w_head.data;
            if (dc_data_gnt_i) w_state_nxt = SB_TAG;
         end
         SB_TAG: begin
            dc_tag_valid_o = 1'b1;
            dc_addr_tag_o  = w_head.addr[PLEN-1:INDEX_W];
            w_state_nxt    = (w_count_nxt != '0) ? SB_REQ : SB_IDLE;
         end
         default: w_state_nxt = SB_IDLE;
      endcase
   end

   always_comb begin
      w_vld_vec = '0;
      w_key_vec = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_vld_vec[i]                  = r_mem[i].valid;
         w_key_vec[i*CMP_W +: CMP_W]   = r_mem[i].addr[INDEX_W-1:3];
      end
   end

   sb_alias_cmp #(
      .N (DEPTH),
      .W (CMP_W)
   ) u_alias_cmp (
      .i_valid (w_vld_vec),
      .i_keys  (w_key_vec),
      .i_probe (ld_addr_i[INDEX_W-1:3]),
      .o_hit   (ld_alias_o)
   );

   assign w_unused_ld = ^{ld_addr_i[PLEN-1:INDEX_W], ld_addr_i[2:0]};

   // Only control state is reset; entry payload is qualified by the valid bits.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state    <= SB_IDLE;
         r_head     <= '0;
         r_tail     <= '0;
         r_count    <= '0;
         r_ack_sent <= 1'b0;
         for (int i = 0; i < DEPTH; i++) r_mem[i].valid <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_count    <= w_count_nxt;
         r_ack_sent <= flush_i && (r_ack_sent || flush_ack_o);
         if (w_pop) begin
            r_mem[r_head].valid <= 1'b0;
            r_head              <= r_head + PTR_W'(1);
         end
         if (w_alloc) begin
            r_mem[r_tail].addr  <= st_addr_i;
            r_mem[r_tail].data  <= st_data_i;
            r_mem[r_tail].be    <= st_be_i;
            r_mem[r_tail].valid <= 1'b1;
            r_tail              <= r_tail + PTR_W'(1);
         end
`ifdef STORE_BUF_COALESCE_EN
         if (w_push && w_merge_hit) begin
            for (int b = 0; b < BE_W; b++) begin
               if (st_be_i[b]) r_mem[w_tail_last].data[8*b +: 8] <= st_data_i[8*b +: 8];
            end
            r_mem[w_tail_last].be <= r_mem[w_tail_last].be | st_be_i;
         end
`endif
      end
   end

endmodule

// File: tb/tb_dcache_store_drain_buffer.sv
// Directed bench for dcache_store_drain_buffer; expectations follow STORE_BUF_COALESCE_EN when defined.
module tb_dcache_store_drain_buffer;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        st_valid_i;
   logic        st_ready_o;
   logic [55:0] st_addr_i;
   logic [63:0] st_data_i;
   logic [7:0]  st_be_i;
   logic [55:0] ld_addr_i;
   logic        ld_alias_o;
   logic        dc_data_req_o;
   logic        dc_data_gnt_i;
   logic [11:0] dc_addr_index_o;
   logic        dc_data_we_o;
   logic [7:0]  dc_data_be_o;
   logic [63:0] dc_data_wdata_o;
   logic        dc_tag_valid_o;
   logic [43:0] dc_addr_tag_o;
   logic        flush_i;
   logic        flush_ack_o;
   logic        empty_o;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk_i = ~clk_i;

   dcache_store_drain_buffer dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .st_valid_i      (st_valid_i),
      .st_ready_o      (st_ready_o),
      .st_addr_i       (st_addr_i),
      .st_data_i       (st_data_i),
      .st_be_i         (st_be_i),
      .ld_addr_i       (ld_addr_i),
      .ld_alias_o      (ld_alias_o),
      .dc_data_req_o   (dc_data_req_o),
      .dc_data_gnt_i   (dc_data_gnt_i),
      .dc_addr_index_o (dc_addr_index_o),
      .dc_data_we_o    (dc_data_we_o),
      .dc_data_be_o    (dc_data_be_o),
      .dc_data_wdata_o (dc_data_wdata_o),
      .dc_tag_valid_o  (dc_tag_valid_o),
      .dc_addr_tag_o   (dc_addr_tag_o),
      .flush_i         (flush_i),
      .flush_ack_o     (flush_ack_o),
      .empty_o         (empty_o)
   );

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [55:0] a, input logic [63:0] d, input logic [7:0] be);
      st_valid_i = 1'b1;
      st_addr_i  = a;
      st_data_i  = d;
      st_be_i    = be;
      tick();
      st_valid_i = 1'b0;
   endtask

   initial begin
      int n_ack;
      int ack_at;
      int last_tag;
      int n_tag;
      int n_wr;
      logic [7:0]  wr_be [2];
      logic [63:0] wr_data [2];

      rst_i = 1'b1; st_valid_i = 1'b0; st_addr_i = '0; st_data_i = '0; st_be_i = '0;
      ld_addr_i = '0; dc_data_gnt_i = 1'b0; flush_i = 1'b0;
      tick();
      tick();
      chk("rst_empty", empty_o, 1);
      chk("rst_ready", st_ready_o, 1);
      chk("rst_req", dc_data_req_o, 0);
      chk("rst_tagv", dc_tag_valid_o, 0);
      chk("rst_ack", flush_ack_o, 0);
      rst_i = 1'b0;

      // Single store, zero-wait grant
      dc_data_gnt_i = 1'b1;
      push(56'h8000_1008, 64'hDEAD_BEEF_0123_4567, 8'hFF);
      chk("s1_empty", empty_o, 0);
      chk("s1_req_c1", dc_data_req_o, 0);
      tick();
      chk("s1_req", dc_data_req_o, 1);
      chk("s1_we", dc_data_we_o, 1);
      chk("s1_index", dc_addr_index_o, 12'h008);
      chk("s1_data", dc_data_wdata_o, 64'hDEAD_BEEF_0123_4567);
      chk("s1_be", dc_data_be_o, 8'hFF);
      tick();
      chk("s1_tagv", dc_tag_valid_o, 1);
      chk("s1_tag", dc_addr_tag_o, 44'h80001);
      chk("s1_req_off", dc_data_req_o, 0);
      tick();
      chk("s1_empty_end", empty_o, 1);
      chk("s1_tagv_end", dc_tag_valid_o, 0);

      // Fill to full with grant withheld
      dc_data_gnt_i = 1'b0;
      for (int k = 0; k < 4; k++) push(56'h3000 + 56'(k * 'h40), 64'hA5A5_0000_0000_0000 | 64'(k), 8'h01 << k);
      st_valid_i = 1'b1; st_addr_i = 56'h3100; st_data_i = 64'h0BAD; st_be_i = 8'hFF;
      chk("full_ready", st_ready_o, 0);
      for (int i = 0; i < 5; i++) begin
         chk("wait_req", dc_data_req_o, 1);
         chk("wait_index", dc_addr_index_o, 12'h000);
         chk("wait_data", dc_data_wdata_o, 64'hA5A5_0000_0000_0000);
         chk("wait_be", dc_data_be_o, 8'h01);
         chk("wait_tagv", dc_tag_valid_o, 0);
         tick();
      end
      dc_data_gnt_i = 1'b1;
      tick();
      chk("full_tag0", dc_tag_valid_o, 1);
      chk("full_tag0_addr", dc_addr_tag_o, 44'h3);
      chk("full_tag_ready", st_ready_o, 0);
      tick();
      st_valid_i = 1'b0;
      for (int k = 1; k < 4; k++) begin
         chk("drain_req", dc_data_req_o, 1);
         chk("drain_index", dc_addr_index_o, 12'(k * 'h40));
         chk("drain_data", dc_data_wdata_o, 64'hA5A5_0000_0000_0000 | 64'(k));
         chk("drain_be", dc_data_be_o, 8'h01 << k);
         tick();
         chk("drain_tagv", dc_tag_valid_o, 1);
         tick();
      end
      chk("drain_empty", empty_o, 1);
      chk("drain_idle", dc_data_req_o, 0);

      // Load aliasing
      dc_data_gnt_i = 1'b0;
      push(56'h1010, 64'h77, 8'hFF);
      ld_addr_i = 56'h5010;
      #1 chk("alias_hit", ld_alias_o, 1);
      ld_addr_i = 56'h1018;
      #1 chk("alias_miss", ld_alias_o, 0);
      ld_addr_i = 56'h5010;
      dc_data_gnt_i = 1'b1;
      tick();
      chk("alias_inflight", ld_alias_o, 1);
      tick();
      tick();
      chk("alias_cleared", ld_alias_o, 0);
      chk("alias_empty", empty_o, 1);

      // Flush with three pending entries
      dc_data_gnt_i = 1'b0;
      push(56'h4000, 64'h1, 8'hFF);
      push(56'h4008, 64'h2, 8'hFF);
      push(56'h4010, 64'h3, 8'hFF);
      flush_i = 1'b1;
      st_valid_i = 1'b1; st_addr_i = 56'h4018;
      #1 chk("flush_ready", st_ready_o, 0);
      dc_data_gnt_i = 1'b1;
      n_ack = 0; ack_at = -1; last_tag = -1; n_tag = 0;
      for (int i = 0; i < 20; i++) begin
         if (dc_tag_valid_o) begin last_tag = i; n_tag++; end
         if (flush_ack_o) begin n_ack++; ack_at = i; end
         tick();
      end
      st_valid_i = 1'b0;
      chk("flush_ntag", 64'(n_tag), 3);
      chk("flush_nack", 64'(n_ack), 1);
      chk("flush_ack_at", 64'(ack_at), 64'(last_tag + 1));
      flush_i = 1'b0;
      tick();
      chk("flush_ack_low", flush_ack_o, 0);
      chk("flush_ready_back", st_ready_o, 1);

      // Reset during the tag phase
      ld_addr_i = 56'h6028;
      push(56'h6028, 64'h55, 8'h3C);
      tick();
      tick();
      chk("rtag_tagv", dc_tag_valid_o, 1);
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      chk("rtag_empty", empty_o, 1);
      chk("rtag_ready", st_ready_o, 1);
      chk("rtag_tagv0", dc_tag_valid_o, 0);
      chk("rtag_tag0", dc_addr_tag_o, 0);
      chk("rtag_req", dc_data_req_o, 0);
      chk("rtag_we", dc_data_we_o, 0);
      chk("rtag_idx", dc_addr_index_o, 0);
      chk("rtag_be", dc_data_be_o, 0);
      chk("rtag_wdata", dc_data_wdata_o, 0);
      chk("rtag_alias", ld_alias_o, 0);
      chk("rtag_ack", flush_ack_o, 0);
      tick();
      chk("rtag_req_after", dc_data_req_o, 0);

      // Coalescing of two halves of one word
      dc_data_gnt_i = 1'b0;
      push(56'h2000, 64'h0000_0000_1122_3344, 8'h0F);
      push(56'h2004, 64'h5566_7788_0000_0000, 8'hF0);
      dc_data_gnt_i = 1'b1;
      n_wr = 0;
      wr_be[0] = '0; wr_be[1] = '0; wr_data[0] = '0; wr_data[1] = '0;
      for (int i = 0; i < 10; i++) begin
         if (dc_data_req_o && dc_data_gnt_i) begin
            if (n_wr < 2) begin wr_be[n_wr] = dc_data_be_o; wr_data[n_wr] = dc_data_wdata_o; end
            n_wr++;
         end
         tick();
      end
`ifdef STORE_BUF_COALESCE_EN
      chk("coal_nwr", 64'(n_wr), 1);
      chk("coal_be", wr_be[0], 8'hFF);
      chk("coal_data", wr_data[0], 64'h5566_7788_1122_3344);
`else
      chk("coal_nwr", 64'(n_wr), 2);
      chk("coal_be0", wr_be[0], 8'h0F);
      chk("coal_data0", wr_data[0], 64'h0000_0000_1122_3344);
      chk("coal_be1", wr_be[1], 8'hF0);
      chk("coal_data1", wr_data[1], 64'h5566_7788_0000_0000);
`endif
      chk("coal_empty", empty_o, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
